// File: rtl/vga_sync_receiver_if.sv
// VGA pixel-stream bundle between a VGA timing source (master) and the
// sync receiver (slave): sync/colour pins in, recovered pixel stream out.
interface vga_sync_receiver_if;
  logic       hsync_in;
  logic       vsync_in;
  logic [5:0] rgb_in;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [5:0] pix_data;
  logic       locked;
  logic       frame_done;
  logic       sync_err;
  logic [7:0] err_cnt;

  modport master (
    output hsync_in, vsync_in, rgb_in,
    input  pix_valid, pix_x, pix_y, pix_data, locked, frame_done, sync_err, err_cnt
  );

  modport slave (
    input  hsync_in, vsync_in, rgb_in,
    output pix_valid, pix_x, pix_y, pix_data, locked, frame_done, sync_err, err_cnt
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: rebuilds pixel coordinates from hsync/vsync falling edges,
// checks line/frame timing, locks after LOCK_FRAMES good frames.
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic               vga_clk,
  input logic               reset,
  vga_sync_receiver_if.slave bus
);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0]  CNT_SAT  = '1;
  localparam logic [9:0]  CNT_PRE  = 10'd1022;
  localparam logic [10:0] H_LEN    = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN    = 11'(V_TOTAL);
  localparam logic [9:0]  H_LO     = 10'(H_START);
  localparam logic [9:0]  H_HI     = 10'(H_START + H_VIS);
  localparam logic [9:0]  V_LO     = 10'(V_START);
  localparam logic [9:0]  V_HI     = 10'(V_START + V_VIS);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

  logic       r_hs1, r_hs1_d, r_vs1, r_vs1_d;
  logic [5:0] r_rgb1;
  logic [9:0] r_h_cnt, r_v_cnt;
  logic       r_hs_seen, r_vs_seen, r_frame_bad;
  logic [7:0] r_good_cnt;
  state_t     r_state;

  logic       r_pix_valid, r_locked, r_frame_done, r_sync_err;
  logic [9:0] r_pix_x, r_pix_y;
  logic [5:0] r_pix_data;
  logic [7:0] r_err_cnt;

  logic       w_hs_fall, w_vs_fall;
  logic [9:0] w_h_cur, w_v_cur;
  logic       w_line_err, w_hsat_err, w_frame_chk, w_frame_good, w_frame_err, w_any_err;
  logic       w_vis;

  assign w_hs_fall = r_hs1_d & ~r_hs1;
  assign w_vs_fall = r_vs1_d & ~r_vs1;

  // w_h_cur/w_v_cur are the coordinates of the sample now in stage 1; the
  // registered counters hold those of the previous sample.
  always_comb begin
    w_h_cur = r_h_cnt;
    if (w_hs_fall)             w_h_cur = '0;
    else if (r_h_cnt != CNT_SAT) w_h_cur = r_h_cnt + 10'd1;
    w_v_cur = r_v_cnt;
    if (w_vs_fall)                          w_v_cur = '0;
    else if (w_hs_fall && r_v_cnt != CNT_SAT) w_v_cur = r_v_cnt + 10'd1;
  end

  assign w_line_err   = w_hs_fall & r_hs_seen & (({1'b0, r_h_cnt} + 11'd1) != H_LEN);
  assign w_hsat_err   = ~w_hs_fall & (r_h_cnt == CNT_PRE);
  assign w_frame_chk  = w_vs_fall & r_vs_seen;
  assign w_frame_good = w_frame_chk & ~r_frame_bad & ~w_line_err & ~w_hsat_err &
                        (({1'b0, r_v_cnt} + {10'd0, w_hs_fall}) == V_LEN);
  assign w_frame_err  = w_frame_chk & ~w_frame_good;
  assign w_any_err    = w_line_err | w_hsat_err | w_frame_err;

  assign w_vis = (r_state == LOCKED) && (w_h_cur >= H_LO) && (w_h_cur < H_HI) &&
                 (w_v_cur >= V_LO) && (w_v_cur < V_HI);

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      r_hs1        <= 1'b0;
      r_hs1_d      <= 1'b0;
      r_vs1        <= 1'b0;
      r_vs1_d      <= 1'b0;
      r_rgb1       <= '0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_hs_seen    <= 1'b0;
      r_vs_seen    <= 1'b0;
      r_frame_bad  <= 1'b0;
      r_good_cnt   <= '0;
      r_state      <= UNLOCKED;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_data   <= '0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_hs1   <= bus.hsync_in;
      r_hs1_d <= r_hs1;
      r_vs1   <= bus.vsync_in;
      r_vs1_d <= r_vs1;
      r_rgb1  <= bus.rgb_in;
      r_h_cnt <= w_h_cur;
      r_v_cnt <= w_v_cur;

      r_pix_valid <= w_vis;
      r_pix_x     <= w_vis ? (w_h_cur - H_LO) : '0;
      r_pix_y     <= w_vis ? (w_v_cur - V_LO) : '0;
      r_pix_data  <= w_vis ? r_rgb1 : '0;

      r_sync_err <= w_any_err;
      if (w_any_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_vs_fall)      r_frame_bad <= 1'b0;
      else if (w_any_err) r_frame_bad <= 1'b1;
      if (w_hs_fall) r_hs_seen <= 1'b1;
      if (w_vs_fall) r_vs_seen <= 1'b1;

      r_frame_done <= 1'b0;
      case (r_state)
        UNLOCKED: begin
          if (w_vs_fall) begin
            r_state    <= ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (w_any_err) begin
            r_good_cnt <= '0;
          end else if (w_frame_good) begin
            if (r_good_cnt + 8'd1 == LOCK_N) begin
              r_state    <= LOCKED;
              r_locked   <= 1'b1;
              r_good_cnt <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + 8'd1;
            end
          end
        end
        LOCKED: begin
          // Unlock re-arms edge tracking so the next vsync only restarts acquisition.
          if (w_any_err) begin
            r_state   <= UNLOCKED;
            r_locked  <= 1'b0;
            r_hs_seen <= 1'b0;
            r_vs_seen <= 1'b0;
          end else if (w_frame_good) begin
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= UNLOCKED;
      endcase
    end
  end

  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_data   = r_pix_data;
  assign bus.locked     = r_locked;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced 40x20 raster: frame table with
// expected error/frame_done/valid counts, pixel scoreboard, and corner sequences.
module tb_vga_sync_receiver;
  localparam int HT = 40, HST = 8, HV = 24, VT = 20, VST = 4, VV = 12;
  localparam int HSW = 4, VSW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_receiver_if bus ();

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_START(HST), .H_VIS(HV),
    .V_TOTAL(VT), .V_START(VST), .V_VIS(VV),
    .LOCK_FRAMES(2)
  ) dut (
    .vga_clk(clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int cyc;
    int x;
    int y;
    int d;
  } px_t;

  typedef struct {
    int lines;
    int short_ln;
    int short_len;
    bit sb;
    int e_err;
    int e_fd;
    int e_valid;
    int e_lock;
  } frame_t;

  px_t    sb_q[$];
  frame_t tbl[16];
  int     n_checks = 0;
  int     n_errors = 0;
  int     ncyc = 0;
  int     cum_err = 0, cum_fd = 0, cum_valid = 0;
  int     last_err_cyc = -1, last_fd_cyc = -1;
  bit     sb_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // One clock: sample DUT outputs at this negedge, then drive the next pin values.
  task automatic tick(input logic hs, input logic vs, input logic [5:0] rgb,
                      input bit push, input int ex, input int ey);
    px_t e;
    if (bus.sync_err)   begin cum_err++; last_err_cyc = ncyc; end
    if (bus.frame_done) begin cum_fd++;  last_fd_cyc  = ncyc; end
    if (bus.pix_valid)  cum_valid++;
    if (sb_on) begin
      if (bus.pix_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_valid", int'(bus.pix_valid), 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_latency", ncyc, e.cyc);
          chk("sb_pix_x", int'(bus.pix_x), e.x);
          chk("sb_pix_y", int'(bus.pix_y), e.y);
          chk("sb_pix_data", int'(bus.pix_data), e.d);
        end
      end else begin
        chk("idle_zero", int'({bus.pix_x, bus.pix_y, bus.pix_data}), 0);
      end
    end
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.rgb_in   = rgb;
    if (push) sb_q.push_back('{ncyc + 2, ex, ey, int'(rgb)});
    ncyc++;
    @(negedge clk);
  endtask

  task automatic tick_px(input int h, input int v);
    bit vis;
    int x, y;
    logic [5:0] c;
    vis = (h >= HST) && (h < HST + HV) && (v >= VST) && (v < VST + VV);
    x = h - HST;
    y = v - VST;
    c = vis ? 6'((x ^ y) & 63) : 6'd0;
    tick(h >= HSW, v >= VSW, c, vis && sb_on, x, y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic gen_frame(input int lines, input int short_ln, input int short_len, input int stop_v);
    for (int v = 0; v < lines && v < stop_v; v++) begin
      for (int h = 0; h < ((v == short_ln) ? short_len : HT); h++) tick_px(h, v);
    end
  endtask

  task automatic hline();
    for (int h = 0; h < HT; h++) tick(h >= HSW, 1'b1, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    idle(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(4);
  endtask

  initial begin
    int st, e0, f0, v0, exp_cum, s0;
    tbl[0]  = '{VT,   -1, HT, 1'b0, 0, 0,   0, 0};
    tbl[1]  = '{VT,   -1, HT, 1'b0, 0, 0,   0, 0};
    tbl[2]  = '{VT,   -1, HT, 1'b0, 0, 0, 288, 1};
    tbl[3]  = '{VT,   -1, HT, 1'b1, 0, 1, 288, 1};
    tbl[4]  = '{VT,   -1, HT, 1'b0, 0, 1, 288, 1};
    tbl[5]  = '{VT,    6, HT-1, 1'b0, 1, 1, 72, 0};
    tbl[6]  = '{VT,   -1, HT, 1'b0, 0, 0,   0, 0};
    tbl[7]  = '{VT,   -1, HT, 1'b0, 0, 0,   0, 0};
    tbl[8]  = '{VT,   -1, HT, 1'b0, 0, 0, 288, 1};
    tbl[9]  = '{VT,   -1, HT, 1'b0, 0, 1, 288, 1};
    tbl[10] = '{VT-1, -1, HT, 1'b0, 0, 1, 288, 1};
    tbl[11] = '{VT,   -1, HT, 1'b0, 1, 0,   0, 0};
    tbl[12] = '{VT,   -1, HT, 1'b0, 0, 0,   0, 0};
    tbl[13] = '{VT,   -1, HT, 1'b0, 0, 0,   0, 0};
    tbl[14] = '{VT,   -1, HT, 1'b0, 0, 0, 288, 1};
    tbl[15] = '{VT,   -1, HT, 1'b0, 0, 1, 288, 1};

    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.rgb_in   = '0;
    @(negedge clk);
    idle(5);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_pix_valid", int'(bus.pix_valid), 0);
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
    chk("rst_pulses", int'({bus.sync_err, bus.frame_done}), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(4);

    // Acquisition, locked scoreboard, short line, short frame, relock
    exp_cum = 0;
    for (int f = 0; f < 16; f++) begin
      st = ncyc; e0 = cum_err; f0 = cum_fd; v0 = cum_valid;
      sb_on = tbl[f].sb;
      gen_frame(tbl[f].lines, tbl[f].short_ln, tbl[f].short_len, VT);
      sb_on = 1'b0;
      exp_cum += tbl[f].e_err;
      chk($sformatf("frame%0d_sync_err", f), cum_err - e0, tbl[f].e_err);
      chk($sformatf("frame%0d_frame_done", f), cum_fd - f0, tbl[f].e_fd);
      chk($sformatf("frame%0d_valid_cnt", f), cum_valid - v0, tbl[f].e_valid);
      chk($sformatf("frame%0d_locked", f), int'(bus.locked), tbl[f].e_lock);
      chk($sformatf("frame%0d_err_cnt", f), int'(bus.err_cnt), exp_cum);
      if (tbl[f].e_fd != 0) chk($sformatf("frame%0d_fd_time", f), last_fd_cyc, st + 2);
      if (tbl[f].sb) chk("sb_leftover", sb_q.size(), 0);
    end

    // hsync stall: one saturation error, then one line-length error on resume
    pulse_reset();
    s0 = ncyc; e0 = cum_err;
    for (int l = 0; l < 3; l++) hline();
    for (int i = 0; i < 1200; i++) tick(1'b1, 1'b1, 6'd0, 1'b0, 0, 0);
    chk("stall_sat_err_cnt", cum_err - e0, 1);
    chk("stall_sat_err_time", last_err_cyc, s0 + 2 * HT + 1023 + 2);
    for (int i = 0; i < 800; i++) tick(1'b1, 1'b1, 6'd0, 1'b0, 0, 0);
    for (int l = 0; l < 3; l++) hline();
    idle(4);
    chk("stall_total_errs", cum_err - e0, 2);
    chk("stall_err_cnt", int'(bus.err_cnt), 2);

    // Continuous line faults: err_cnt saturates
    e0 = cum_err;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b1, 6'd0, 1'b0, 0, 0);
      tick(1'b1, 1'b1, 6'd0, 1'b0, 0, 0);
      tick(1'b0, 1'b1, 6'd0, 1'b0, 0, 0);
      tick(1'b0, 1'b1, 6'd0, 1'b0, 0, 0);
    end
    idle(4);
    chk("stress_pulses", cum_err - e0, 300);
    chk("stress_err_cnt_sat", int'(bus.err_cnt), 255);

    // Lock, then reset asynchronously mid-frame while pixels are valid
    for (int f = 0; f < 3; f++) gen_frame(VT, -1, HT, VT);
    gen_frame(VT, -1, HT, 8);
    for (int h = 0; h < 20; h++) tick_px(h, 8);
    chk("pre_rst_valid", int'(bus.pix_valid), 1);
    chk("pre_rst_x", int'(bus.pix_x), 10);
    chk("pre_rst_y", int'(bus.pix_y), 4);
    chk("pre_rst_data", int'(bus.pix_data), 10 ^ 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.pix_valid), 0);
    chk("async_rst_locked", int'(bus.locked), 0);
    chk("async_rst_err_cnt", int'(bus.err_cnt), 0);
    chk("async_rst_pix", int'({bus.pix_x, bus.pix_y, bus.pix_data}), 0);
    @(negedge clk);
    idle(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(4);
    gen_frame(VT, -1, HT, VT);
    gen_frame(VT, -1, HT, VT);
    chk("rearm_not_locked", int'(bus.locked), 0);
    gen_frame(VT, -1, HT, VT);
    chk("rearm_locked", int'(bus.locked), 1);
    chk("rearm_err_cnt", int'(bus.err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
